// File: rtl/aes_spi_scheduler_if.sv
// Request/response bundle between the requesters and the AES SPI scheduler.
//   req_valid  [1:0]        per-requester request, held until the matching ack
//   req_block  [255:0]      {blk1, blk0}
//   req_key    [2*NK*32-1:0] {key1, key0}
//   req_ack    [1:0]        one-cycle pulse when a request is captured
//   resp_valid              one-cycle pulse when resp_data is fresh
//   resp_id                 requester that owns resp_data
//   resp_data  [127:0]      returned block, held until the next resp_valid
//   busy                    high from grant through the resp_valid cycle
// master = requester side, slave = scheduler side.
interface aes_spi_scheduler_if #(
    parameter int NK = 4
);
    logic [1:0]           req_valid;
    logic [255:0]         req_block;
    logic [2*NK*32-1:0]   req_key;
    logic [1:0]           req_ack;
    logic                 resp_valid;
    logic                 resp_id;
    logic [127:0]         resp_data;
    logic                 busy;

    modport master (
        output req_valid, req_block, req_key,
        input  req_ack, resp_valid, resp_id, resp_data, busy
    );

    modport slave (
        input  req_valid, req_block, req_key,
        output req_ack, resp_valid, resp_id, resp_data, busy
    );
endinterface

// File: rtl/aes_spi_scheduler.sv
// Shares one AES SPI slave between two requesters with round-robin arbitration
// and runs each transaction as: chip-select setup period, 128-bit block out,
// NK*32-bit key out (both LSB-first), WAIT_BITS idle periods, 128-bit result
// in (LSB-first), chip-select hold period, response.
// SCLK comes from an enable-tick divider in the clk domain: each bit period is
// 2*DIV clk cycles, low half first.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   bus             request/response bundle (slave modport)
//   spi_sclk_o      serial clock
//   spi_cs_n_o      chip select, active low
//   spi_mosi_o      serial data to the slave
//   spi_miso_i      serial data from the slave
//   spi_phase_o     0 = load/wait, 1 = readback
module aes_spi_scheduler #(
    parameter int NK        = 4,
    parameter int DIV       = 50,
    parameter int WAIT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    aes_spi_scheduler_if.slave  bus,
    output logic                spi_sclk_o,
    output logic                spi_cs_n_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i,
    output logic                spi_phase_o
);

    localparam int KW    = NK * 32;
    localparam int MAXKB = (KW > WAIT_BITS) ? KW : WAIT_BITS;
    localparam int MAXB  = (MAXKB > 128) ? MAXKB : 128;
    localparam int BW    = $clog2(MAXB);
    localparam int DW    = $clog2(2 * DIV);

    localparam logic [BW-1:0] BLK_LAST  = BW'(127);
    localparam logic [BW-1:0] KEY_LAST  = BW'(KW - 1);
    localparam logic [BW-1:0] WAIT_LAST = BW'(WAIT_BITS - 1);
    localparam logic [DW-1:0] HALF_END  = DW'(DIV - 1);
    localparam logic [DW-1:0] PER_END   = DW'(2 * DIV - 1);

    typedef enum logic [3:0] {
        IDLE, GRANT, CS_SETUP, SEND_BLK, SEND_KEY, WAIT, RECV, CS_HOLD, DONE
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   div_q;
    logic [BW-1:0]   bit_q;
    logic            rr_last_q;
    logic [1:0]      req_ack_q;
    logic            resp_valid_q;
    logic            resp_id_q;
    logic [127:0]    resp_data_q;
    logic            busy_q;
    logic            sclk_q;
    logic            cs_n_q;
    logic            mosi_q;
    logic            phase_q;
    logic [127:0]    blk_q;
    logic [KW-1:0]   key_q;
    logic [127:0]    rx_q;

    logic            grant_id_d;
    logic            half_end;
    logic            per_end;

    // A lone request wins outright; round-robin only breaks ties.
    always_comb begin
        grant_id_d = bus.req_valid[1] & (~bus.req_valid[0] | ~rr_last_q);
    end

    // half_end: last cycle of the low half, so the next edge raises SCLK and
    // is the MISO sample edge. per_end: last cycle of the bit period.
    assign half_end = (div_q == HALF_END);
    assign per_end  = (div_q == PER_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_last_q    <= 1'b1;
            req_ack_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
            sclk_q       <= 1'b0;
            cs_n_q       <= 1'b1;
            mosi_q       <= 1'b0;
            phase_q      <= 1'b0;
            div_q        <= '0;
            bit_q        <= '0;
        end else begin
            req_ack_q    <= '0;
            resp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.req_valid) begin
                        state_q   <= GRANT;
                        req_ack_q <= grant_id_d ? 2'b10 : 2'b01;
                        rr_last_q <= grant_id_d;
                        resp_id_q <= grant_id_d;
                        busy_q    <= 1'b1;
                    end
                end
                GRANT: begin
                    state_q <= CS_SETUP;
                    cs_n_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                    phase_q <= 1'b0;
                    div_q   <= '0;
                    bit_q   <= '0;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    // Serial states share the bit-period divider.
                    div_q <= per_end ? '0 : div_q + 1'b1;
                    if (half_end && state_q != CS_HOLD) sclk_q <= 1'b1;
                    if (per_end) begin
                        sclk_q <= 1'b0;
                        bit_q  <= bit_q + 1'b1;
                        case (state_q)
                            CS_SETUP: begin
                                state_q <= SEND_BLK;
                                mosi_q  <= blk_q[0];
                                bit_q   <= '0;
                            end
                            SEND_BLK: begin
                                if (bit_q == BLK_LAST) begin
                                    state_q <= SEND_KEY;
                                    mosi_q  <= key_q[0];
                                    bit_q   <= '0;
                                end else begin
                                    // blk_q shifts on this same edge.
                                    mosi_q <= blk_q[1];
                                end
                            end
                            SEND_KEY: begin
                                if (bit_q == KEY_LAST) begin
                                    state_q <= WAIT;
                                    mosi_q  <= 1'b0;
                                    bit_q   <= '0;
                                end else begin
                                    mosi_q <= key_q[1];
                                end
                            end
                            WAIT: begin
                                if (bit_q == WAIT_LAST) begin
                                    state_q <= RECV;
                                    phase_q <= 1'b1;
                                    bit_q   <= '0;
                                end
                            end
                            RECV: begin
                                if (bit_q == BLK_LAST) begin
                                    state_q <= CS_HOLD;
                                    cs_n_q  <= 1'b1;
                                    phase_q <= 1'b0;
                                    bit_q   <= '0;
                                end
                            end
                            CS_HOLD: begin
                                state_q      <= DONE;
                                resp_valid_q <= 1'b1;
                                resp_data_q  <= rx_q;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are fully rewritten by every
    // transaction before being observed.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && (|bus.req_valid)) begin
            blk_q <= grant_id_d ? bus.req_block[255:128] : bus.req_block[127:0];
            key_q <= grant_id_d ? bus.req_key[2*KW-1:KW] : bus.req_key[KW-1:0];
        end
        if (per_end && state_q == SEND_BLK) blk_q <= blk_q >> 1;
        if (per_end && state_q == SEND_KEY) key_q <= key_q >> 1;
        // First bit received ends up in bit 0 after 128 shifts.
        if (half_end && state_q == RECV) rx_q <= {spi_miso_i, rx_q[127:1]};
    end

    assign bus.req_ack    = req_ack_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.busy       = busy_q;
    assign spi_sclk_o     = sclk_q;
    assign spi_cs_n_o     = cs_n_q;
    assign spi_mosi_o     = mosi_q;
    assign spi_phase_o    = phase_q;

endmodule

// File: tb/tb_aes_spi_scheduler.sv
module tb_aes_spi_scheduler;

    localparam logic [127:0] B0 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R0 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] R2 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    localparam logic [127:0] BB = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [255:0] KB = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RB = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: NK=4, DIV=2, WAIT_BITS=16
    aes_spi_scheduler_if #(.NK(4)) a_bus ();
    logic a_sclk, a_cs_n, a_mosi, a_miso, a_phase;
    aes_spi_scheduler #(.NK(4), .DIV(2), .WAIT_BITS(16)) u_a (
        .clk(clk), .reset(reset), .bus(a_bus),
        .spi_sclk_o(a_sclk), .spi_cs_n_o(a_cs_n), .spi_mosi_o(a_mosi),
        .spi_miso_i(a_miso), .spi_phase_o(a_phase)
    );

    // DUT B: NK=8, DIV=1, WAIT_BITS=16
    aes_spi_scheduler_if #(.NK(8)) b_bus ();
    logic b_sclk, b_cs_n, b_mosi, b_miso, b_phase;
    aes_spi_scheduler #(.NK(8), .DIV(1), .WAIT_BITS(16)) u_b (
        .clk(clk), .reset(reset), .bus(b_bus),
        .spi_sclk_o(b_sclk), .spi_cs_n_o(b_cs_n), .spi_mosi_o(b_mosi),
        .spi_miso_i(b_miso), .spi_phase_o(b_phase)
    );

    // Slave models: record MOSI on rising SCLK during phase 0, serve the
    // response LSB-first during phase 1.
    logic [511:0] a_ld_bits, b_ld_bits;
    int           a_ld_cnt = 0, a_rx_cnt = 0;
    int           b_ld_cnt = 0, b_rx_cnt = 0, b_cs_cyc = 0;
    logic [127:0] a_resp = '0, b_resp = '0;
    time          b_last = 0, b_period = 0;

    always @(posedge a_sclk) begin
        if (!a_cs_n) begin
            if (!a_phase) begin
                if (a_ld_cnt < 512) a_ld_bits[a_ld_cnt[8:0]] = a_mosi;
                a_ld_cnt++;
            end else begin
                a_rx_cnt++;
            end
        end
    end
    assign a_miso = (a_rx_cnt < 128) ? a_resp[a_rx_cnt[6:0]] : 1'b0;

    always @(posedge b_sclk) begin
        b_period = $time - b_last;
        b_last   = $time;
        if (!b_cs_n) begin
            if (!b_phase) begin
                if (b_ld_cnt < 512) b_ld_bits[b_ld_cnt[8:0]] = b_mosi;
                b_ld_cnt++;
            end else begin
                b_rx_cnt++;
            end
        end
    end
    assign b_miso = (b_rx_cnt < 128) ? b_resp[b_rx_cnt[6:0]] : 1'b0;
    always @(negedge clk) if (!b_cs_n) b_cs_cyc++;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic id, input logic [127:0] blk, input logic [127:0] key);
        if (id) begin
            a_bus.req_block[255:128] = blk;
            a_bus.req_key[255:128]   = key;
        end else begin
            a_bus.req_block[127:0]   = blk;
            a_bus.req_key[127:0]     = key;
        end
        a_bus.req_valid[id] = 1'b1;
    endtask

    // One full transaction on DUT A, checking grant, payload, latency, result.
    task automatic run_a(input string tag, input logic [1:0] exp_ack, input logic [127:0] rword);
        logic         got;
        logic         id;
        logic [127:0] eblk, ekey;
        int           t_ack;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (a_bus.req_ack != 2'b00) got = 1'b1;
        end
        check_eq({tag, ".ack"}, 256'(a_bus.req_ack), 256'(exp_ack));
        if (!got) return;
        id    = a_bus.req_ack[1];
        t_ack = cyc;
        check_eq({tag, ".busy_ack"}, 256'(a_bus.busy), 256'(1'b1));
        eblk = id ? a_bus.req_block[255:128] : a_bus.req_block[127:0];
        ekey = id ? a_bus.req_key[255:128] : a_bus.req_key[127:0];
        // Requester releases the request and scribbles over its data.
        a_bus.req_valid[id] = 1'b0;
        if (id) a_bus.req_block[255:128] = ~eblk; else a_bus.req_block[127:0] = ~eblk;
        if (id) a_bus.req_key[255:128]   = ~ekey; else a_bus.req_key[127:0]   = ~ekey;
        a_resp   = rword;
        a_ld_cnt = 0;
        a_rx_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (a_bus.resp_valid) got = 1'b1;
        end
        check_eq({tag, ".resp_seen"}, 256'(got), 256'(1'b1));
        check_eq({tag, ".latency"}, 256'(cyc - t_ack), 256'(1609));
        check_eq({tag, ".resp_id"}, 256'(a_bus.resp_id), 256'(id));
        check_eq({tag, ".resp_data"}, 256'(a_bus.resp_data), 256'(rword));
        check_eq({tag, ".busy_done"}, 256'(a_bus.busy), 256'(1'b1));
        check_eq({tag, ".ld_cnt"}, 256'(a_ld_cnt), 256'(273));
        check_eq({tag, ".ld_bits"}, a_ld_bits[256:1], {ekey, eblk});
        @(negedge clk);
        check_eq({tag, ".idle"}, 256'({a_bus.resp_valid, a_bus.busy}), 256'(2'b00));
    endtask

    initial begin
        logic got;
        int   t_ack;
        int   n_rv;
        reset = 1'b1;
        a_bus.req_valid = '0; a_bus.req_block = '0; a_bus.req_key = '0;
        b_bus.req_valid = '0; b_bus.req_block = '0; b_bus.req_key = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check_eq("rst.ack", 256'(a_bus.req_ack), 256'(0));
        check_eq("rst.resp", 256'({a_bus.resp_valid, a_bus.resp_id, a_bus.busy}), 256'(0));
        check_eq("rst.data", 256'(a_bus.resp_data), 256'(0));
        check_eq("rst.spi", 256'({a_sclk, a_cs_n, a_mosi, a_phase}), 256'(4'b0100));
        reset = 1'b0;

        // Single request from requester 0
        set_a(1'b0, B0, K0);
        run_a("single", 2'b01, R0);

        // Both valid from reset: 0 first, then 1
        reset = 1'b1;
        set_a(1'b0, B1, K1);
        set_a(1'b1, B0, K0);
        @(negedge clk);
        reset = 1'b0;
        run_a("both0", 2'b01, R1);
        run_a("both1", 2'b10, R2);

        // Requester 1 alone twice, then a tie
        set_a(1'b1, B0, K1);
        run_a("r1a", 2'b10, R0);
        set_a(1'b1, B1, K0);
        run_a("r1b", 2'b10, R1);
        set_a(1'b0, B0, K0);
        set_a(1'b1, B1, K1);
        run_a("tie", 2'b01, R2);
        a_bus.req_valid = 2'b00;

        // Reset during key bit 40
        set_a(1'b0, B0, K0);
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (a_bus.req_ack != 2'b00) got = 1'b1;
        end
        check_eq("mid.ack", 256'(a_bus.req_ack), 256'(2'b01));
        a_bus.req_valid = 2'b00;
        a_resp = R1; a_ld_cnt = 0; a_rx_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (a_ld_cnt >= 170) got = 1'b1;
        end
        check_eq("mid.reach_key40", 256'(got), 256'(1'b1));
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid.cs_sclk", 256'({a_cs_n, a_sclk}), 256'(2'b10));
        check_eq("mid.busy", 256'(a_bus.busy), 256'(1'b0));
        check_eq("mid.data_clr", 256'(a_bus.resp_data), 256'(0));
        reset = 1'b0;
        n_rv = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (a_bus.resp_valid) n_rv++;
        end
        check_eq("mid.no_resp", 256'(n_rv), 256'(0));
        set_a(1'b0, B0, K0);
        run_a("after_rst", 2'b01, R0);

        // DUT B: NK=8, DIV=1
        b_bus.req_block = {128'h0, BB};
        b_bus.req_key   = {256'h0, KB};
        b_bus.req_valid = 2'b01;
        b_resp = RB;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (b_bus.req_ack != 2'b00) got = 1'b1;
        end
        check_eq("b.ack", 256'(b_bus.req_ack), 256'(2'b01));
        t_ack = cyc;
        b_bus.req_valid = 2'b00;
        b_ld_cnt = 0; b_rx_cnt = 0; b_cs_cyc = 0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (b_bus.resp_valid) got = 1'b1;
        end
        check_eq("b.resp_seen", 256'(got), 256'(1'b1));
        check_eq("b.latency", 256'(cyc - t_ack), 256'(1061));
        check_eq("b.resp_data", 256'(b_bus.resp_data), 256'(RB));
        check_eq("b.ld_cnt", 256'(b_ld_cnt), 256'(401));
        check_eq("b.blk_bits", 256'(b_ld_bits[128:1]), 256'(BB));
        check_eq("b.key_bits", b_ld_bits[384:129], KB);
        check_eq("b.cs_low", 256'(b_cs_cyc), 256'(1058));
        check_eq("b.sclk_period", 256'(b_period), 256'(20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
